ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, RAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-004 SHALL have parameter RD_LAT, default 2, cycles from o_ram_en (read) to valid i_ram_dout (1..8).
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_req  input  NUM_REQ  per-requester access request.
REQ-008 SHALL have port i_we  input  NUM_REQ  per-requester write (1) / read (0).
REQ-009 SHALL have port i_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at slice k.
REQ-010 SHALL have port i_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, requester k at slice k.
REQ-011 SHALL have port o_gnt  output  NUM_REQ  one-hot grant pulse.
REQ-012 SHALL have port o_rvalid  output  NUM_REQ  one-hot read-data-valid pulse.
REQ-013 SHALL have port o_rdata  output  DATA_WIDTH  read data, shared by all requesters.
REQ-014 SHALL have ports o_ram_en, o_ram_we (1 bit), o_ram_addr (ADDR_WIDTH), o_ram_din (DATA_WIDTH), outputs driving one RAM port.
REQ-015 SHALL have port i_ram_dout  input  DATA_WIDTH  RAM read data.

Function
REQ-016 SHALL evaluate eligible requests each cycle; eligible = i_req[k] AND NOT o_gnt[k] (a request granted this cycle is ignored for one cycle).
REQ-017 SHALL, at the edge after an eligible request wins, register o_gnt[k]=1 for exactly one cycle together with o_ram_en=1, o_ram_we=i_we[k], o_ram_addr/o_ram_din from slice k.
REQ-018 SHALL issue at most one RAM access per cycle; with no eligible request, o_ram_en=0, o_ram_we=0, o_gnt=0, and o_ram_addr/o_ram_din hold their last values.
REQ-019 SHALL select the winner round-robin: search from pointer ptr upward, wrapping modulo NUM_REQ; after granting k, ptr = (k+1) mod NUM_REQ; ptr unchanged when nothing granted.
REQ-020 SHALL require requesters to hold i_req, i_we, i_addr, i_wdata stable until o_gnt[k] is seen; the arbiter does not check this.
REQ-021 SHALL, for every granted read, push {valid, requester index} into an RD_LAT-deep shift pipeline aligned to i_ram_dout.
REQ-022 SHALL, when the pipeline output is valid, assert o_rvalid[index]=1 for one cycle with o_rdata=i_ram_dout in that same cycle (registered-out: o_rvalid/o_rdata appear RD_LAT+1 cycles after o_ram_en rising edge of the read).
REQ-023 SHALL return read data strictly in grant order; back-to-back reads from different requesters produce back-to-back o_rvalid pulses.
REQ-024 SHALL never assert a write-granted requester's o_rvalid.
REQ-025 SHALL allow a single continuously requesting requester at most one grant every two cycles; two or more requesters SHALL yield a grant every cycle.

Reset
REQ-026 SHALL, while i_rst_n=0, immediately force o_gnt=0, o_rvalid=0, o_rdata=0, o_ram_en=0, o_ram_we=0, o_ram_addr=0, o_ram_din=0, ptr=0, and clear the read pipeline.
REQ-027 SHALL discard in-flight reads on reset; no o_rvalid is produced for accesses granted before reset.
REQ-028 SHALL accept requests on the first rising edge after i_rst_n deasserts.

Configuration
REQ-029 SHALL, when macro RAM_ARB_FIXED_PRIO_EN is defined, use fixed priority (lowest index wins) and omit ptr; REQ-016/017/018/021-028 unchanged.
REQ-030 SHALL, when RAM_ARB_FIXED_PRIO_EN is undefined, use round-robin per REQ-019.

Verification
REQ-031 SHALL cover: reset, then i_req=4'b0001, i_we=0, addr0=3 -> o_gnt=0001, o_ram_en=1, o_ram_addr=3 next cycle; o_rvalid=0001 with o_rdata=RAM[3] RD_LAT+1 cycles after o_ram_en.
REQ-032 SHALL cover: i_req=4'b1111 held constant (round-robin) -> grants 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-033 SHALL cover: requester 2 writes 8'hA5 to addr 5, then requester 0 reads addr 5 -> o_rvalid=0001, o_rdata=8'hA5.
REQ-034 SHALL cover: only requester 1 held requesting -> o_gnt[1] pulses every second cycle, o_ram_en=0 between.
REQ-035 SHALL cover: i_rst_n pulled low one cycle after a read grant -> all outputs 0 immediately, no o_rvalid after reset release.
REQ-036 SHALL cover: with RAM_ARB_FIXED_PRIO_EN defined and i_req=4'b0110 held -> grants alternate 0010,0100 (requester 1 first).

Source files
------------

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one RAM port among NUM_REQ requesters, one access per
//               cycle, and routes read data back in grant order.
//               Define RAM_ARB_FIXED_PRIO_EN for fixed (lowest index) priority
//               instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_ram_en,
    output logic                          o_ram_we,
    output logic [ADDR_WIDTH-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_din,
    input  logic [DATA_WIDTH-1:0]         i_ram_dout
);

    localparam int                 c_IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0]    r_gnt;
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    logic [c_IDX_W-1:0]    r_gnt_idx;
    logic [RD_LAT-1:0]     r_pipe_vld;
    logic [c_IDX_W-1:0]    r_pipe_idx [RD_LAT];
    logic [NUM_REQ-1:0]    r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [NUM_REQ-1:0]    w_elig;
    logic                  w_win_vld;
    logic [c_IDX_W-1:0]    w_win_idx;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // A requester granted this cycle sits out one cycle so it can drop i_req.
    assign w_elig = i_req & ~r_gnt;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_vld = 1'b1;
                w_win_idx = c_IDX_W'(i);
            end
        end
    end
`else
    logic [c_IDX_W-1:0] r_ptr;
    logic [NUM_REQ-1:0] w_rot;
    logic [c_IDX_W-1:0] w_off;
    logic [c_IDX_W:0]   w_sum;

    // Rotate so bit 0 is the requester at the pointer; lowest set bit wins.
    assign w_rot = NUM_REQ'({w_elig, w_elig} >> r_ptr);

    always_comb begin
        w_win_vld = 1'b0;
        w_off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_win_vld = 1'b1;
                w_off     = c_IDX_W'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (c_IDX_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (c_IDX_W + 1)'(NUM_REQ);
        end
        w_win_idx = w_sum[c_IDX_W-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_win_vld) begin
            r_ptr <= (w_win_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == c_IDX_W'(i)) begin
                w_sel_we    = i_we[i];
                w_sel_addr  = i_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = i_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt      <= '0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_gnt_idx  <= '0;
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_idx[i] <= '0;
            end
            r_rvalid   <= '0;
            r_rdata    <= '0;
        end else begin
            r_gnt    <= w_win_vld ? (c_ONE_HOT0 << w_win_idx) : '0;
            r_ram_en <= w_win_vld;
            r_ram_we <= w_win_vld & w_sel_we;
            if (w_win_vld) begin
                r_ram_addr <= w_sel_addr;
                r_ram_din  <= w_sel_wdata;
                r_gnt_idx  <= w_win_idx;
            end

            // Stage 0 loads while the read is on the RAM port, so the last
            // stage lines up with i_ram_dout RD_LAT cycles later.
            r_pipe_vld[0] <= r_ram_en & ~r_ram_we;
            r_pipe_idx[0] <= r_gnt_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end

            r_rvalid <= r_pipe_vld[RD_LAT-1] ? (c_ONE_HOT0 << r_pipe_idx[RD_LAT-1]) : '0;
            if (r_pipe_vld[RD_LAT-1]) begin
                r_rdata <= i_ram_dout;
            end
        end
    end

    assign o_gnt      = r_gnt;
    assign o_rvalid   = r_rvalid;
    assign o_rdata    = r_rdata;
    assign o_ram_en   = r_ram_en;
    assign o_ram_we   = r_ram_we;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_din  = r_ram_din;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Scoreboard bench for ram_port_arbiter with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 3;
    localparam int DW      = 8;
    localparam int RD_LAT  = 2;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    we;
    logic [NUM_REQ*AW-1:0] addr;
    logic [NUM_REQ*DW-1:0] wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rvalid;
    logic [DW-1:0]         rdata;
    logic                  ram_en;
    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DW-1:0]         ram_din;
    logic [DW-1:0]         ram_dout;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RD_LAT    (RD_LAT)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_we      (we),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .o_gnt     (gnt),
        .o_rvalid  (rvalid),
        .o_rdata   (rdata),
        .o_ram_en  (ram_en),
        .o_ram_we  (ram_we),
        .o_ram_addr(ram_addr),
        .o_ram_din (ram_din),
        .i_ram_dout(ram_dout)
    );

    // Behavioural RAM: mem[a] starts at 8'h10 + a; read data valid RD_LAT
    // cycles after the cycle o_ram_en is high.
    logic [DW-1:0] mem     [1<<AW];
    logic [DW-1:0] rd_pipe [RD_LAT];
    logic          ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h10 + DW'(i);
            ram_ready <= 1'b1;
        end else if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        rd_pipe[0] <= mem[ram_addr];
        for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign ram_dout = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NUM_REQ-1:0] gnt;
        logic               we;
        logic [AW-1:0]      addr;
        logic [DW-1:0]      din;
        int                 at;
    } gexp_t;

    typedef struct {
        logic [NUM_REQ-1:0] rv;
        logic [DW-1:0]      data;
        int                 at;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ge;
    rexp_t re;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_gnt(input int k, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int at);
        gexp_t e;
        e.gnt  = 4'b0001 << k;
        e.we   = w;
        e.addr = a;
        e.din  = d;
        e.at   = at;
        gq.push_back(e);
    endtask

    task automatic exp_rd(input int k, input logic [DW-1:0] d, input int at);
        rexp_t e;
        e.rv   = 4'b0001 << k;
        e.data = d;
        e.at   = at;
        rq.push_back(e);
    endtask

    // Monitor: fields packed as {cycle, one-hot, we, addr, data}.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ram_en_vs_gnt", {63'd0, ram_en}, {63'd0, |gnt});
            if (gnt != '0) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", {60'd0, gnt}, 64'd0);
                end else begin
                    ge = gq.pop_front();
                    check("gnt", {cyc, gnt, ram_we, ram_addr, ram_din},
                                 {ge.at, ge.gnt, ge.we, ge.addr, ge.din});
                end
            end else if (gq.size() > 0 && gq[0].at <= cyc) begin
                ge = gq.pop_front();
                check("gnt_missing", {cyc, gnt}, {ge.at, ge.gnt});
            end
            if (rvalid != '0) begin
                if (rq.size() == 0) begin
                    check("rvalid_unexpected", {60'd0, rvalid}, 64'd0);
                end else begin
                    re = rq.pop_front();
                    check("rvalid", {cyc, rvalid, rdata}, {re.at, re.rv, re.data});
                end
            end else if (rq.size() > 0 && rq[0].at <= cyc) begin
                re = rq.pop_front();
                check("rvalid_missing", {cyc, rvalid}, {re.at, re.rv});
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-shot access: request held until the grant is visible, then dropped.
    task automatic single(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] rexp);
        req[k]            = 1'b1;
        we[k]             = w;
        addr[k*AW +: AW]  = a;
        wdata[k*DW +: DW] = d;
        exp_gnt(k, w, a, d, cyc + 1);
        if (!w) exp_rd(k, rexp, cyc + 2 + RD_LAT);
        step();
        req[k] = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},      {60'd0, gnt},      64'd0);
        check({tag, "_rvalid"},   {60'd0, rvalid},   64'd0);
        check({tag, "_rdata"},    {56'd0, rdata},    64'd0);
        check({tag, "_ram_en"},   {63'd0, ram_en},   64'd0);
        check({tag, "_ram_we"},   {63'd0, ram_we},   64'd0);
        check({tag, "_ram_addr"}, {61'd0, ram_addr}, 64'd0);
        check({tag, "_ram_din"},  {56'd0, ram_din},  64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        step(2);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Read from requester 0 right after reset release
        single(0, 1'b0, 3'd3, 8'h00, 8'h13);
        step(RD_LAT + 2);

        // Requester 2 writes A5 to addr 5, requester 0 reads it back
        single(2, 1'b1, 3'd5, 8'hA5, 8'h00);
        single(0, 1'b0, 3'd5, 8'h00, 8'hA5);
        step(RD_LAT + 2);

        // Lone requester 1 held: grant only every second cycle
        req[1]        = 1'b1;
        we[1]         = 1'b0;
        addr[AW +: AW] = 3'd1;
        wdata[DW +: DW] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            exp_gnt(1, 1'b0, 3'd1, 8'h00, cyc + 1 + 2*i);
            exp_rd(1, 8'h11, cyc + 2 + 2*i + RD_LAT);
        end
        step(5);
        req[1] = 1'b0;
        step(RD_LAT + 3);

        // Reset one cycle after a read grant drops the in-flight read
        req[2]            = 1'b1;
        we[2]             = 1'b0;
        addr[2*AW +: AW]  = 3'd2;
        exp_gnt(2, 1'b0, 3'd2, 8'hA5, cyc + 1);
        step();
        req[2] = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        step(2);
        rst_n = 1'b1;
        step(RD_LAT + 4);

`ifdef RAM_ARB_FIXED_PRIO_EN
        // Fixed priority with requesters 1 and 2 held: alternate, 1 first
        we    = 4'b0000;
        addr  = {3'd0, 3'd2, 3'd1, 3'd0};
        wdata = '0;
        for (int i = 0; i < 2; i++) begin
            exp_gnt(1, 1'b0, 3'd1, 8'h00, cyc + 1 + 2*i);
            exp_rd(1, 8'h11, cyc + 2 + 2*i + RD_LAT);
            exp_gnt(2, 1'b0, 3'd2, 8'h00, cyc + 2 + 2*i);
            exp_rd(2, 8'h12, cyc + 3 + 2*i + RD_LAT);
        end
        req = 4'b0110;
        step(4);
        req = '0;
        step(RD_LAT + 4);
`else
        // Round-robin with all four held; requester 1 writes 77 to addr 7,
        // requester 3 reads it back two cycles later
        we    = 4'b0010;
        addr  = {3'd7, 3'd5, 3'd7, 3'd0};
        wdata = {8'h00, 8'h00, 8'h77, 8'h00};
        exp_gnt(0, 1'b0, 3'd0, 8'h00, cyc + 1);
        exp_gnt(1, 1'b1, 3'd7, 8'h77, cyc + 2);
        exp_gnt(2, 1'b0, 3'd5, 8'h00, cyc + 3);
        exp_gnt(3, 1'b0, 3'd7, 8'h00, cyc + 4);
        exp_gnt(0, 1'b0, 3'd0, 8'h00, cyc + 5);
        exp_rd(0, 8'h10, cyc + 2 + RD_LAT);
        exp_rd(2, 8'hA5, cyc + 4 + RD_LAT);
        exp_rd(3, 8'h77, cyc + 5 + RD_LAT);
        exp_rd(0, 8'h10, cyc + 6 + RD_LAT);
        req = 4'b1111;
        step(5);
        req = '0;
        step(RD_LAT + 4);
`endif

        check("gnt_queue_drained", 64'(gq.size()), 64'd0);
        check("rd_queue_drained",  64'(rq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
